// File: rtl/pipo_rr_arbiter.sv
// Round-robin write arbiter owning a shared N-bit PIPO register.
// One requester is granted per IDLE/ACK slot pair; the ack is registered and one-hot.
module pipo_rr_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                     CLK,
    input  logic                     res,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*N-1:0]        D,
    output logic [N-1:0]             Q,
    output logic [NREQ-1:0]          ack,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     valid
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    data_q, data_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            valid_q, valid_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win;

    // First set request at or after the pointer, wrapping modulo NREQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0]   p);
        logic [PW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = PW'(idx);
            end
        end
        return w;
    endfunction

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] w);
        if (int'(w) == NREQ - 1) begin
            return '0;
        end
        return w + PW'(1);
    endfunction

    assign win = rr_pick(req, ptr_q);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ack_d   = '0;
        owner_d = owner_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (clr) begin
            // Clear wins over any grant; pointer and owner are deliberately kept.
            data_d  = '0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        data_d  = D[int'(win)*N +: N];
                        owner_d = win;
                        valid_d = 1'b1;
                        ack_d   = NREQ'(1) << win;
                        ptr_d   = rr_next(win);
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (res) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            ack_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Q     = data_q;
    assign ack   = ack_q;
    assign owner = owner_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Bench for pipo_rr_arbiter: directed scenarios plus randomized traffic
// compared against a slot-level round-robin reference model.
module tb_pipo_rr_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic            CLK;
    logic            res;
    logic            clr;
    logic [NREQ-1:0] req;
    logic [NREQ*N-1:0] D;
    logic [N-1:0]    Q;
    logic [NREQ-1:0] ack;
    logic [1:0]      owner;
    logic            valid;

    int errors;
    int checks;

    // Reference model state
    logic [N-1:0]    m_q;
    logic [NREQ-1:0] m_ack;
    int              m_owner;
    logic            m_valid;
    int              m_next;   // requester with first claim on the next slot
    bit              m_in_ack; // a write happened last edge, so this slot is the ack slot

    pipo_rr_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .CLK  (CLK),
        .res  (res),
        .clr  (clr),
        .req  (req),
        .D    (D),
        .Q    (Q),
        .ack  (ack),
        .owner(owner),
        .valid(valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_edge();
        int w;
        if (res) begin
            m_q = '0; m_ack = '0; m_owner = 0; m_valid = 1'b0; m_next = 0; m_in_ack = 0;
        end else if (clr) begin
            m_q = '0; m_ack = '0; m_valid = 1'b0; m_in_ack = 0;
        end else if (m_in_ack) begin
            m_ack = '0; m_in_ack = 0;
        end else if (req != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(m_next + k) % NREQ]) w = (m_next + k) % NREQ;
            m_q      = D[w*N +: N];
            m_owner  = w;
            m_valid  = 1'b1;
            m_ack    = '0;
            m_ack[w] = 1'b1;
            m_next   = (w + 1) % NREQ;
            m_in_ack = 1;
        end
    endtask

    // Advance one rising edge (inputs were set after the falling edge) and settle.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic [NREQ-1:0] rq);
        @(negedge CLK);
        res = r; clr = c; req = rq;
    endtask

    task automatic test_reset();
        D = 32'hDDCCBBAA;
        drive(1'b1, 1'b0, 4'b1111);
        step(); step();
        checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", Q); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        drive(1'b0, 1'b0, 4'b1111);
        step();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL reset_first_grant_ack: got %b expected 0001", ack); end
        checks++; if (Q !== 8'hAA) begin errors++; $display("FAIL reset_first_grant_q: got %h expected aa", Q); end
        drive(1'b0, 1'b0, 4'b0000);
        step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack_drop: got %b expected 0000", ack); end
    endtask

    task automatic test_single_write();
        D = '0;
        D[23:16] = 8'hA5;
        drive(1'b0, 1'b0, 4'b0100);
        step();
        checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL single_q: got %h expected a5", Q); end
        checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d expected 2", owner); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", valid); end
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", ack); end
        drive(1'b0, 1'b0, 4'b0000);
        step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_len: got %b expected 0000", ack); end
        step();
        checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL single_hold_q: got %h expected a5", Q); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_d;
        drive(1'b1, 1'b0, 4'b0000);
        step();
        for (int i = 0; i < NREQ; i++) D[i*N +: N] = 8'h10 + 8'(i * 17);
        drive(1'b0, 1'b0, 4'b1111);
        for (int g = 0; g < 5; g++) begin
            step();
            exp_d = 8'h10 + 8'((g % NREQ) * 17);
            checks++; if (owner !== 2'(g % NREQ)) begin errors++; $display("FAIL rr_owner[%0d]: got %0d expected %0d", g, owner, g % NREQ); end
            checks++; if (ack !== 4'(1 << (g % NREQ))) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", g, ack, 4'(1 << (g % NREQ))); end
            checks++; if (Q !== exp_d) begin errors++; $display("FAIL rr_q[%0d]: got %h expected %h", g, Q, exp_d); end
            step();
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rr_ack_gap[%0d]: got %b expected 0000", g, ack); end
        end
    endtask

    task automatic test_wrap_skip();
        drive(1'b1, 1'b0, 4'b0000);
        step();
        D = 32'h44332211;
        drive(1'b0, 1'b0, 4'b1000);
        step();
        checks++; if (owner !== 2'd3) begin errors++; $display("FAIL wrap_owner3: got %0d expected 3", owner); end
        drive(1'b0, 1'b0, 4'b0101);
        step();
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL wrap_ack_slot: got %b expected 0000", ack); end
        step();
        checks++; if (owner !== 2'd0 || Q !== 8'h11) begin errors++; $display("FAIL wrap_to0: got owner %0d q %h expected owner 0 q 11", owner, Q); end
        step();
        step();
        checks++; if (owner !== 2'd2 || ack !== 4'b0100) begin errors++; $display("FAIL wrap_skip2: got owner %0d ack %b expected owner 2 ack 0100", owner, ack); end
        drive(1'b0, 1'b0, 4'b0000);
        step();
    endtask

    task automatic test_clear();
        D = 32'h00007700 | 32'h3C;
        drive(1'b0, 1'b0, 4'b0001);
        step();
        checks++; if (Q !== 8'h3C) begin errors++; $display("FAIL clr_setup_q: got %h expected 3c", Q); end
        drive(1'b0, 1'b1, 4'b0010);
        step();
        checks++; if (Q !== 8'h00 || valid !== 1'b0) begin errors++; $display("FAIL clr_in_ack: got q %h valid %b expected q 00 valid 0", Q, valid); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL clr_forces_ack: got %b expected 0000", ack); end
        step();
        checks++; if (ack !== 4'b0000 || owner !== 2'd0) begin errors++; $display("FAIL clr_no_grant: got ack %b owner %0d expected ack 0000 owner 0", ack, owner); end
        drive(1'b0, 1'b0, 4'b0010);
        step();
        checks++; if (owner !== 2'd1 || Q !== 8'h77 || ack !== 4'b0010) begin errors++; $display("FAIL clr_release: got owner %0d q %h ack %b expected owner 1 q 77 ack 0010", owner, Q, ack); end
        drive(1'b0, 1'b0, 4'b0000);
        step();
    endtask

    task automatic test_precedence();
        D = 32'h0F0E0D0C;
        drive(1'b0, 1'b0, 4'b0100);
        step();
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL prec_setup: got %b expected 0100", ack); end
        drive(1'b1, 1'b1, 4'b1111);
        step();
        checks++; if (Q !== 8'h00 || ack !== 4'b0000 || owner !== 2'd0 || valid !== 1'b0) begin
            errors++; $display("FAIL prec_reset: got q %h ack %b owner %0d valid %b expected all zero", Q, ack, owner, valid);
        end
        drive(1'b0, 1'b0, 4'b1111);
        step();
        checks++; if (ack !== 4'b0001 || Q !== 8'h0C) begin errors++; $display("FAIL prec_after: got ack %b q %h expected ack 0001 q 0c", ack, Q); end
        drive(1'b0, 1'b0, 4'b0000);
        step();
    endtask

    task automatic test_random();
        int since_grant[NREQ];
        for (int i = 0; i < NREQ; i++) since_grant[i] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            res = ($urandom_range(0, 63) == 0);
            clr = ($urandom_range(0, 15) == 0);
            req = 4'($urandom);
            D   = $urandom;
            step();
            checks++;
            if (Q !== m_q || ack !== m_ack || owner !== 2'(m_owner) || valid !== m_valid) begin
                errors++;
                $display("FAIL random[%0d]: got q %h ack %b owner %0d valid %b expected q %h ack %b owner %0d valid %b",
                         c, Q, ack, owner, valid, m_q, m_ack, m_owner, m_valid);
            end
            checks++;
            if (!$onehot0(ack)) begin errors++; $display("FAIL random_onehot[%0d]: got %b expected at most one bit", c, ack); end
        end
        drive(1'b0, 1'b0, 4'b0000);
        step();
    endtask

    initial begin
        errors = 0; checks = 0;
        res = 1'b1; clr = 1'b0; req = '0; D = '0;
        m_q = '0; m_ack = '0; m_owner = 0; m_valid = 1'b0; m_next = 0; m_in_ack = 0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_wrap_skip();
        test_clear();
        test_precedence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
